// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the instruction-fetch path (read-only) and the
// data-memory path (read/write) share one single-port memory. Each access
// takes WAIT_STATES+1 ACCESS cycles followed by a one-cycle DONE that pulses
// the winner's ACK.
//
// Build option: define ROUND_ROBIN_EN to alternate grants on simultaneous
// requests. Left undefined, data always wins a tie against fetch.
module mem_port_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The wait-state counter is 4 bits wide, so WAIT_STATES must stay in 0..15.
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic          grant_d_reg;   // 1 = data port owns the current transaction
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          mem_en_reg;
  logic          mem_we_reg;    // doubles as the latched write flag during ACCESS
  logic          i_ack_reg;
  logic          d_ack_reg;
  logic          busy_reg;
  logic          pick_d;        // arbitration result, only meaningful in IDLE

`ifdef ROUND_ROBIN_EN
  logic last_grant_reg;         // 1 = data was granted last

  // On a tie, grant whoever did not win last time; a lone request always wins.
  always_comb begin
    pick_d = D_REQ && !(I_REQ && last_grant_reg);
  end
`else
  // Fixed priority: any data request beats a fetch request.
  always_comb begin
    pick_d = D_REQ;
  end
`endif

  // Transaction sequencer: latches the winner in IDLE, holds the memory
  // interface for the ACCESS window, then pulses the ACK for one DONE cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      grant_d_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      mem_en_reg  <= 1'b0;
      mem_we_reg  <= 1'b0;
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          i_ack_reg <= 1'b0;
          d_ack_reg <= 1'b0;
          if (I_REQ || D_REQ) begin
            state_reg   <= ACCESS;
            grant_d_reg <= pick_d;
            addr_reg    <= pick_d ? D_ADDR : I_ADDR;
            // A fetch never writes, so its write data is forced to zero.
            wdata_reg   <= pick_d ? D_WDATA : '0;
            mem_we_reg  <= pick_d && D_WE;
            mem_en_reg  <= 1'b1;
            busy_reg    <= 1'b1;
            cnt_reg     <= WS_LOAD;
`ifdef ROUND_ROBIN_EN
            last_grant_reg <= pick_d;
`endif
          end
        end

        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            state_reg  <= DONE;
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            // Reads capture memory data in the last ACCESS cycle; writes
            // leave the read-data register untouched.
            if (!mem_we_reg) begin
              rdata_reg <= MEM_RDATA;
            end
            i_ack_reg <= !grant_d_reg;
            d_ack_reg <= grant_d_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          i_ack_reg <= 1'b0;
          d_ack_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign MEM_EN    = mem_en_reg;
  assign MEM_WE    = mem_we_reg;
  assign MEM_ADDR  = addr_reg;
  assign MEM_WDATA = wdata_reg;
  assign I_ACK     = i_ack_reg;
  assign D_ACK     = d_ack_reg;
  assign I_RDATA   = rdata_reg;
  assign D_RDATA   = rdata_reg;
  assign BUSY      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Four instances with WAIT_STATES of 1, 3, 0
// and 15 share one clock. A transaction-level model predicts every output on
// every cycle from timestamps (start / ack cycle of the current transaction),
// and directed tests add literal expectations for latency, grant order and
// read data.
module tb_mem_port_arbiter;

  localparam int N = 4;
  // WAIT_STATES per instance, instance 0 in the low nibble.
  localparam logic [15:0] WS_PACK = {4'd15, 4'd0, 4'd3, 4'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [N];
  logic        i_req   [N];
  logic [15:0] i_addr  [N];
  logic        d_req   [N];
  logic        d_we    [N];
  logic [15:0] d_addr  [N];
  logic [15:0] d_wdata [N];

  logic        i_ack     [N];
  logic [15:0] i_rdata   [N];
  logic        d_ack     [N];
  logic [15:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [15:0] mem_addr  [N];
  logic [15:0] mem_wdata [N];
  logic [15:0] mem_rdata [N];
  logic        busy      [N];

  // Memory macro stand-in: combinational read, written on the clock edge.
  logic [15:0] bmem [N][256];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mem_port_arbiter #(
        .AW(16),
        .DW(16),
        .WAIT_STATES(int'(WS_PACK[gi*4 +: 4]))
      ) u_dut (
        .CLK      (clk),
        .RST_N    (rst_n[gi]),
        .I_REQ    (i_req[gi]),
        .I_ADDR   (i_addr[gi]),
        .I_ACK    (i_ack[gi]),
        .I_RDATA  (i_rdata[gi]),
        .D_REQ    (d_req[gi]),
        .D_WE     (d_we[gi]),
        .D_ADDR   (d_addr[gi]),
        .D_WDATA  (d_wdata[gi]),
        .D_ACK    (d_ack[gi]),
        .D_RDATA  (d_rdata[gi]),
        .MEM_EN   (mem_en[gi]),
        .MEM_WE   (mem_we[gi]),
        .MEM_ADDR (mem_addr[gi]),
        .MEM_WDATA(mem_wdata[gi]),
        .MEM_RDATA(mem_rdata[gi]),
        .BUSY     (busy[gi])
      );
      assign mem_rdata[gi] = bmem[gi][mem_addr[gi][7:0]];
    end
  endgenerate

  function automatic logic [15:0] init_word(input int a);
    return 16'hBEFF ^ 16'(a);
  endfunction

  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < N; k++)
        for (int a = 0; a < 256; a++)
          bmem[k][a] <= init_word(a);
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        if (mem_en[k] && mem_we[k])
          bmem[k][mem_addr[k][7:0]] <= mem_wdata[k];
    end
  end

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  bit          m_valid  [N];
  bit          m_active [N];
  bit          m_fresh  [N];
  bit          m_port   [N];   // 1 = data
  bit          m_we     [N];
  bit          m_last   [N];   // 1 = data granted last
  logic [15:0] m_addr   [N];
  logic [15:0] m_wdata  [N];
  logic [15:0] m_rdata  [N];
  int          m_start  [N];
  int          m_ack    [N];
  logic [15:0] ref_mem  [N][256];
  bit          ref_ready = 1'b0;

  function automatic int ws_of(input int k);
    return int'(WS_PACK[k*4 +: 4]);
  endfunction

  function automatic bit pick_data(input bit ir, input bit dr, input bit last);
`ifdef ROUND_ROBIN_EN
    return dr && !(ir && last);
`else
    return dr;
`endif
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ref_ready) begin
      for (int k = 0; k < N; k++)
        for (int a = 0; a < 256; a++)
          ref_mem[k][a] <= init_word(a);
      ref_ready <= 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (!rst_n[k]) begin
        m_valid[k]  <= 1'b1;
        m_active[k] <= 1'b0;
        m_fresh[k]  <= 1'b1;
        m_rdata[k]  <= 16'h0;
        m_last[k]   <= 1'b1;
      end else if (m_valid[k]) begin
        if (m_active[k]) begin
          if (cyc == m_ack[k] - 1) begin
            if (m_we[k]) ref_mem[k][m_addr[k][7:0]] <= m_wdata[k];
            else         m_rdata[k] <= ref_mem[k][m_addr[k][7:0]];
          end
          if (cyc == m_ack[k]) m_active[k] <= 1'b0;
        end else if (i_req[k] || d_req[k]) begin
          m_active[k] <= 1'b1;
          m_fresh[k]  <= 1'b0;
          m_port[k]   <= pick_data(i_req[k], d_req[k], m_last[k]);
          m_last[k]   <= pick_data(i_req[k], d_req[k], m_last[k]);
          m_we[k]     <= pick_data(i_req[k], d_req[k], m_last[k]) && d_we[k];
          m_addr[k]   <= pick_data(i_req[k], d_req[k], m_last[k]) ? d_addr[k] : i_addr[k];
          m_wdata[k]  <= pick_data(i_req[k], d_req[k], m_last[k]) ? d_wdata[k] : 16'h0;
          m_start[k]  <= cyc + 1;
          m_ack[k]    <= cyc + 2 + ws_of(k);
        end
      end
    end
  end

  function automatic bit f_acc(input int k);
    return m_active[k] && (cyc >= m_start[k]) && (cyc < m_ack[k]);
  endfunction

  function automatic bit f_done(input int k);
    return m_active[k] && (cyc == m_ack[k]);
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (m_valid[k]) begin
        chk("mem_en",  k, mem_en[k],  f_acc(k));
        chk("mem_we",  k, mem_we[k],  f_acc(k) && m_we[k]);
        chk("busy",    k, busy[k],    f_acc(k) || f_done(k));
        chk("i_ack",   k, i_ack[k],   f_done(k) && !m_port[k]);
        chk("d_ack",   k, d_ack[k],   f_done(k) && m_port[k]);
        chk("i_rdata", k, i_rdata[k], m_rdata[k]);
        chk("d_rdata", k, d_rdata[k], m_rdata[k]);
        if (f_acc(k)) begin
          chk("mem_addr",  k, mem_addr[k],  m_addr[k]);
          chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
        end
        if (m_fresh[k]) begin
          chk("rst_mem_addr",  k, mem_addr[k],  16'h0);
          chk("rst_mem_wdata", k, mem_wdata[k], 16'h0);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int          lat;
    int          en;
    int          we;
    int          adr;
    int          wd;
    int          oth;
    logic [15:0] rd;
  } res_t;

  // Call at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle
  // after the ACK, with the request already dropped.
  task automatic txn(input int k, input bit is_d, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, output res_t r);
    int c0;
    bit got;
    c0 = cyc;
    got = 1'b0;
    r.lat = -1; r.en = 0; r.we = 0; r.adr = 0; r.wd = 0; r.oth = 0; r.rd = 16'h0;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (mem_en[k]) begin
        r.en++;
        if (mem_addr[k] == addr) r.adr++;
        if (mem_wdata[k] == (is_d ? wdata : 16'h0)) r.wd++;
      end
      if (mem_we[k]) r.we++;
      if (is_d ? i_ack[k] : d_ack[k]) r.oth++;
      if (is_d ? d_ack[k] : i_ack[k]) begin
        got = 1'b1;
        r.lat = cyc - c0;
        r.rd = is_d ? d_rdata[k] : i_rdata[k];
      end
      @(posedge clk); #1;
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    d_we[k]  = 1'b0;
    if (!got) chk("ack_timeout", k, 32'd0, 32'd1);
  endtask

  // Both requests raised together; either each drops after its own ACK
  // (hold=0) or both stay high until n ACKs have been seen (hold=1).
  task automatic tie(input int k, input bit hold, input int n, output logic [7:0] ord, output int cnt);
    bit gd, gi_ack;
    ord = 8'h0;
    cnt = 0;
    i_req[k] = 1'b1; i_addr[k] = 16'h0051;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 16'h0050;
    for (int t = 0; t < 200 && cnt < n; t++) begin
      @(negedge clk);
      gd = d_ack[k];
      gi_ack = i_ack[k];
      if (gd || gi_ack) chk("ack_exclusive", k, gd && gi_ack, 1'b0);
      if (gd)     begin ord = {ord[6:0], 1'b1}; cnt++; end
      if (gi_ack) begin ord = {ord[6:0], 1'b0}; cnt++; end
      @(posedge clk); #1;
      if (!hold) begin
        if (gd)     d_req[k] = 1'b0;
        if (gi_ack) i_req[k] = 1'b0;
      end
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        r;
    logic [7:0]  ord;
    int          cnt;
    int          acks;

    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = 16'h0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 16'h0; d_wdata[k] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_mem_en", 0, mem_en[0], 1'b0);
    chk("reset_busy",   0, busy[0],   1'b0);
    chk("reset_rdata",  0, i_rdata[0], 16'h0);
    @(posedge clk); #1;

    // Fetch from 0x0010, WAIT_STATES=1
    txn(0, 1'b0, 1'b0, 16'h0010, 16'h0, r);
    $display("inst0 fetch 0010: lat=%0d en=%0d rd=%h", r.lat, r.en, r.rd);
    chk("fetch_latency", 0, r.lat, 3);
    chk("fetch_en_cycles", 0, r.en, 2);
    chk("fetch_addr_cycles", 0, r.adr, 2);
    chk("fetch_we_cycles", 0, r.we, 0);
    chk("fetch_other_ack", 0, r.oth, 0);
    chk("fetch_rdata", 0, r.rd, 16'hBEEF);

    // Write 0x1234 to 0x0020, then read it back
    txn(0, 1'b1, 1'b1, 16'h0020, 16'h1234, r);
    $display("inst0 write 0020=1234: lat=%0d en=%0d we=%0d", r.lat, r.en, r.we);
    chk("write_we_cycles", 0, r.we, 2);
    chk("write_wdata_cycles", 0, r.wd, 2);
    chk("write_latency", 0, r.lat, 3);
    chk("write_other_ack", 0, r.oth, 0);
    chk("write_keeps_rdata", 0, r.rd, 16'hBEEF);
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0, r);
    $display("inst0 read 0020: lat=%0d rd=%h", r.lat, r.rd);
    chk("readback_rdata", 0, r.rd, 16'h1234);
    chk("readback_we_cycles", 0, r.we, 0);

    // Simultaneous requests, each dropped after its own ACK
    tie(0, 1'b0, 2, ord, cnt);
    $display("inst0 tie drop: acks=%0d order=%b", cnt, ord[1:0]);
    chk("tie_ack_count", 0, cnt, 2);
`ifdef ROUND_ROBIN_EN
    chk("tie_order", 0, ord[1:0], 2'b01);
`else
    chk("tie_order", 0, ord[1:0], 2'b10);
`endif

    // Both requests held across four transactions
    tie(0, 1'b1, 4, ord, cnt);
    $display("inst0 tie hold: acks=%0d order=%b", cnt, ord[3:0]);
    chk("hold_ack_count", 0, cnt, 4);
`ifdef ROUND_ROBIN_EN
    chk("hold_order", 0, ord[3:0], 4'b0101);
`else
    chk("hold_order", 0, ord[3:0], 4'b1111);
`endif

    // Reset in the 2nd ACCESS cycle of a read, WAIT_STATES=3
    txn(1, 1'b0, 1'b0, 16'h0011, 16'h0, r);
    $display("inst1 fetch 0011: lat=%0d en=%0d rd=%h", r.lat, r.en, r.rd);
    chk("ws3_latency", 1, r.lat, 5);
    chk("ws3_rdata", 1, r.rd, 16'hBEEE);
    i_req[1] = 1'b1; i_addr[1] = 16'h0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_mem_en", 1, mem_en[1], 1'b1);
    rst_n[1] = 1'b0; i_req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    $display("inst1 after reset: en=%0d busy=%0d rdata=%h", mem_en[1], busy[1], i_rdata[1]);
    chk("post_reset_mem_en", 1, mem_en[1], 1'b0);
    chk("post_reset_busy", 1, busy[1], 1'b0);
    chk("post_reset_rdata", 1, i_rdata[1], 16'h0);
    chk("post_reset_addr", 1, mem_addr[1], 16'h0);
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (i_ack[1] || d_ack[1]) acks++;
    end
    chk("dropped_read_no_ack", 1, acks, 0);
    @(posedge clk); #1;
    txn(1, 1'b0, 1'b0, 16'h0012, 16'h0, r);
    $display("inst1 fetch 0012 after reset: lat=%0d rd=%h", r.lat, r.rd);
    chk("after_reset_latency", 1, r.lat, 5);
    chk("after_reset_rdata", 1, r.rd, 16'hBEED);

    // WAIT_STATES sweep: 0 and 15, with a back-to-back fetch on the 0 case
    txn(2, 1'b0, 1'b0, 16'h0030, 16'h0, r);
    $display("inst2 fetch 0030: lat=%0d en=%0d rd=%h", r.lat, r.en, r.rd);
    chk("ws0_latency", 2, r.lat, 2);
    chk("ws0_en_cycles", 2, r.en, 1);
    chk("ws0_rdata", 2, r.rd, 16'hBECF);
    txn(2, 1'b0, 1'b0, 16'h0032, 16'h0, r);
    $display("inst2 fetch 0032: lat=%0d rd=%h", r.lat, r.rd);
    chk("ws0_b2b_latency", 2, r.lat, 2);
    chk("ws0_b2b_rdata", 2, r.rd, 16'hBECD);
    txn(3, 1'b1, 1'b0, 16'h0031, 16'h0, r);
    $display("inst3 read 0031: lat=%0d en=%0d rd=%h", r.lat, r.en, r.rd);
    chk("ws15_latency", 3, r.lat, 17);
    chk("ws15_en_cycles", 3, r.en, 16);
    chk("ws15_rdata", 3, r.rd, 16'hBECE);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the instruction-fetch path (read-only) and the data-memory path (read/write).
- Runs each memory transaction as a multi-cycle sequence with a programmable number of wait states, then returns a one-cycle acknowledge.
- Sits between the multi-cycle control unit and datapath on one side and the memory macro on the other. Lets IF and load/store share one memory.

Parameters:
- AW, 16, address width of both requesters and the memory.
- DW, 16, data width.
- WAIT_STATES, 1, extra memory cycles per access. Legal range 0..15; the counter is 4 bits.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- I_REQ  in  1  fetch request; held high until I_ACK.
- I_ADDR  in  AW  fetch address.
- I_ACK  out  1  fetch done; one-cycle pulse.
- I_RDATA  out  DW  fetch read data; valid while I_ACK=1.
- D_REQ  in  1  data request; held high until D_ACK.
- D_WE  in  1  1=write, 0=read.
- D_ADDR  in  AW  data address.
- D_WDATA  in  DW  write data.
- D_ACK  out  1  data done; one-cycle pulse.
- D_RDATA  out  DW  data read data; valid while D_ACK=1.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  DW  memory write data.
- MEM_RDATA  in  DW  memory read data; sampled in the last ACCESS cycle.
- BUSY  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - state=IDLE, counter=0, all outputs 0, internal rdata register 0.
  - Any in-flight transaction is dropped; no ACK is ever issued for it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is pending, stay in IDLE; MEM_EN=0.
  - If any REQ is high, pick the winner and go to ACCESS.
  - On that edge, latch the grant, address, write data and write enable. For a fetch, latched WE=0 and WDATA=0.
  - Load counter=WAIT_STATES.
- Arbitration (default): fixed priority, D over I. When both requests are high, data wins and fetch waits.
- ACCESS:
  - MEM_EN=1. MEM_ADDR, MEM_WDATA and MEM_WE are driven from the latched values for the whole state.
  - Requester inputs are ignored, so changes on them mid-transaction have no effect.
  - Counter decrements each cycle. When counter==0, go to DONE; on a read, capture MEM_RDATA into rdata on that same edge.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- DONE:
  - Exactly one cycle. The granted ACK is 1 and the other ACK is 0; MEM_EN=0, MEM_WE=0.
  - I_RDATA and D_RDATA both show rdata. A write leaves rdata unchanged.
  - Next state is IDLE.
- Latency: a request seen in IDLE in cycle n gives ACK in cycle n+2+WAIT_STATES. With WAIT_STATES=1, ACK is in cycle n+3.
- Handshake:
  - The requester drops REQ on the edge that ends its ACK cycle.
  - REQ high in IDLE always starts a new transaction, so back-to-back requests from one requester are allowed.
  - Throughput is one transaction per WAIT_STATES+3 cycles.
- Requests arriving during ACCESS or DONE wait until the next IDLE cycle.
- ACK is never high for both requesters in the same cycle. ACK is never high outside DONE.
- RDATA holds its value between transactions.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register, reset to 1 (= data).
  - When both requests are high in IDLE, grant the requester that was not granted last. A single request is granted regardless.
  - last_grant updates on every IDLE->ACCESS transition.
  - The first tie after reset goes to fetch.
- Not defined: fixed D-over-I priority; no last_grant register is built.

Test Plan:
- Reset, then hold I_REQ=1 with I_ADDR=0x0010; memory model returns 0xBEEF (WAIT_STATES=1):
  - MEM_EN is high for exactly 2 cycles with MEM_ADDR=0x0010 and MEM_WE=0.
  - I_ACK pulses exactly 1 cycle, 3 cycles after the request was sampled, with I_RDATA=0xBEEF.
  - D_ACK stays 0.
- Write D_WE=1, D_ADDR=0x0020, D_WDATA=0x1234, then read 0x0020:
  - During the write, MEM_WE=1 for all ACCESS cycles and MEM_WDATA=0x1234; D_ACK pulses.
  - The read returns D_RDATA=0x1234.
- I_REQ and D_REQ raised in the same cycle, default build:
  - Data is served first, then fetch; ACK order is D then I; ACKs never overlap.
- Same stimulus with ROUND_ROBIN_EN defined, both requests held for 4 transactions:
  - Grant order is I, D, I, D.
- RST_N pulled low in the 2nd ACCESS cycle of a read (WAIT_STATES=3):
  - Next cycle all outputs are 0 and state is IDLE.
  - No ACK is issued for the dropped read.
  - A request after reset completes normally.
- Sweep WAIT_STATES over 0 and 15:
  - ACCESS length is 1 and 16 cycles respectively.
  - ACK latency is 2 and 17 cycles respectively.
